mem_port_arbiter: RTL and testbench

- Shares the single-ported byte-addressed memory between the instruction-fetch (IF) and load/store (LS) requesters.
- Each cycle it grants at most one request and drives the memory's enable/address/write lines.
- It routes the memory's 1-cycle-latency read data back to the requester that issued the access.
- Arbitration is fixed priority with LS first, plus a starvation guard so IF always makes progress.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 89 ++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/LS requester and memory signals of the memory port arbiter
// slave is the arbiter side; master is the requesters plus memory side.
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_flush;

  logic        ls_req_valid;
  logic        ls_req_we;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - LS-first arbiter for a single-ported memory with IF starvation guard
// Grant is combinational; responses follow acceptance by exactly one cycle.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_IF    = 2'd1;
  localparam logic [1:0] OWN_LS_RD = 2'd2;
  localparam logic [1:0] OWN_LS_WR = 2'd3;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [31:0]      if_data_q, if_data_d;
  logic [31:0]      ls_data_q, ls_data_d;
  logic             grant_if, grant_ls;

  // Gating on i_rst_n keeps every request-side output quiet for the whole reset pulse.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (i_rst_n) begin
      if (bus.ls_req_valid && bus.if_req_valid) begin
        if (starve_cnt_q == LIMIT) grant_if = 1'b1;
        else                       grant_ls = 1'b1;
      end else if (bus.ls_req_valid) begin
        grant_ls = 1'b1;
      end else if (bus.if_req_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    bus.if_req_ready = grant_if;
    bus.ls_req_ready = grant_ls;
    bus.mem_en       = grant_if || grant_ls;
    bus.mem_we       = grant_ls && bus.ls_req_we;
    bus.mem_addr     = grant_ls ? bus.ls_req_addr : (grant_if ? bus.if_req_addr : 32'd0);
    bus.mem_wdata    = grant_ls ? bus.ls_req_wdata : 32'd0;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (grant_if)      owner_d = OWN_IF;
    else if (grant_ls) owner_d = bus.ls_req_we ? OWN_LS_WR : OWN_LS_RD;

    starve_cnt_d = '0;
    if (bus.if_req_valid && !grant_if)
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
  end

  // Read data arrives straight from the memory in the response cycle; the hold
  // registers only keep the last presented value for idle cycles.
  always_comb begin
    bus.if_rsp_valid = (owner_q == OWN_IF) && !bus.if_flush;
    bus.if_rsp_data  = (owner_q == OWN_IF) ? bus.mem_rdata : if_data_q;
    bus.ls_rsp_valid = (owner_q == OWN_LS_RD) || (owner_q == OWN_LS_WR);
    case (owner_q)
      OWN_LS_RD: bus.ls_rsp_data = bus.mem_rdata;
      OWN_LS_WR: bus.ls_rsp_data = 32'd0;
      default:   bus.ls_rsp_data = ls_data_q;
    endcase
    if_data_d = bus.if_rsp_data;
    ls_data_d = bus.ls_rsp_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
      if_data_q    <= 32'd0;
      ls_data_q    <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      if_data_q    <= if_data_d;
      ls_data_q    <= ls_data_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Expected responses are queued at acceptance and compared in the response cycle.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_IF    = 2'd1;
  localparam logic [1:0] OWN_LS_RD = 2'd2;
  localparam logic [1:0] OWN_LS_WR = 2'd3;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  exp_t        exp_q[$];
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int          cnt_m;
  logic [31:0] last_if;
  logic [31:0] last_ls;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: entered at posedge+1 with inputs already driven, returns at next posedge+1.
  task automatic step();
    exp_t        e;
    logic        g_if, g_ls;
    logic [31:0] e_addr, e_wdata;
    #3;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = '{owner: OWN_NONE, data: 32'd0};
    if (e.owner == OWN_IF) last_if = e.data;
    if (e.owner == OWN_LS_RD) last_ls = e.data;
    if (e.owner == OWN_LS_WR) last_ls = 32'd0;
    check("if_rsp_valid", {31'd0, bus.if_rsp_valid}, {31'd0, (e.owner == OWN_IF) && !bus.if_flush});
    check("if_rsp_data", bus.if_rsp_data, last_if);
    check("ls_rsp_valid", {31'd0, bus.ls_rsp_valid},
          {31'd0, (e.owner == OWN_LS_RD) || (e.owner == OWN_LS_WR)});
    check("ls_rsp_data", bus.ls_rsp_data, last_ls);

    g_if = 1'b0;
    g_ls = 1'b0;
    if (bus.ls_req_valid && bus.if_req_valid) begin
      if (cnt_m == STARVE_LIMIT) g_if = 1'b1;
      else                       g_ls = 1'b1;
    end else if (bus.ls_req_valid) g_ls = 1'b1;
    else if (bus.if_req_valid)     g_if = 1'b1;
    e_addr  = g_ls ? bus.ls_req_addr : (g_if ? bus.if_req_addr : 32'd0);
    e_wdata = g_ls ? bus.ls_req_wdata : 32'd0;
    check("if_req_ready", {31'd0, bus.if_req_ready}, {31'd0, g_if});
    check("ls_req_ready", {31'd0, bus.ls_req_ready}, {31'd0, g_ls});
    check("mem_en", {31'd0, bus.mem_en}, {31'd0, g_if || g_ls});
    check("mem_we", {31'd0, bus.mem_we}, {31'd0, g_ls && bus.ls_req_we});
    check("mem_addr", bus.mem_addr, e_addr);
    check("mem_wdata", bus.mem_wdata, e_wdata);

    if (g_if) begin
      exp_q.push_back('{owner: OWN_IF, data: ref_mem[e_addr[9:2]]});
    end else if (g_ls && bus.ls_req_we) begin
      exp_q.push_back('{owner: OWN_LS_WR, data: 32'd0});
      ref_mem[e_addr[9:2]] = bus.ls_req_wdata;
    end else if (g_ls) begin
      exp_q.push_back('{owner: OWN_LS_RD, data: ref_mem[e_addr[9:2]]});
    end else begin
      exp_q.push_back('{owner: OWN_NONE, data: 32'd0});
    end

    if (bus.if_req_valid && !g_if) cnt_m = (cnt_m == STARVE_LIMIT) ? cnt_m : cnt_m + 1;
    else                           cnt_m = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = 32'd0;
    bus.if_flush     = 1'b0;
    bus.ls_req_valid = 1'b0;
    bus.ls_req_we    = 1'b0;
    bus.ls_req_addr  = 32'd0;
    bus.ls_req_wdata = 32'd0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cnt_m   = 0;
    last_if = 32'd0;
    last_ls = 32'd0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'(i) * 32'h0101_0101 + 32'h5a;
      ref_mem[i] = 32'(i) * 32'h0101_0101 + 32'h5a;
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    bus.mem_rdata = 32'd0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state, with requests present to show readies stay low.
    #2;
    bus.if_req_valid = 1'b1;
    bus.ls_req_valid = 1'b1;
    #1;
    check("rst_if_ready", {31'd0, bus.if_req_ready}, 32'd0);
    check("rst_ls_ready", {31'd0, bus.ls_req_ready}, 32'd0);
    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_if_rsp_valid", {31'd0, bus.if_rsp_valid}, 32'd0);
    check("rst_ls_rsp_valid", {31'd0, bus.ls_rsp_valid}, 32'd0);
    check("rst_if_rsp_data", bus.if_rsp_data, 32'd0);
    check("rst_ls_rsp_data", bus.ls_rsp_data, 32'd0);
    idle_inputs();
    @(posedge clk);
    #6;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // IF only read of 0x10.
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0010;
    step();
    idle_inputs();
    step();

    // LS write then LS read of 0x20.
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b1;
    bus.ls_req_addr  = 32'h0000_0020;
    bus.ls_req_wdata = 32'h1234_5678;
    step();
    bus.ls_req_we    = 1'b0;
    bus.ls_req_wdata = 32'hFFFF_0000;
    step();
    idle_inputs();
    step();

    // LS write followed by IF read of the same address.
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b1;
    bus.ls_req_addr  = 32'hABCD_0030;
    bus.ls_req_wdata = 32'hCAFE_F00D;
    step();
    idle_inputs();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'hABCD_0030;
    step();
    idle_inputs();
    step();

    // Continuous contention: LS x4, IF, LS x4, IF ...
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0040;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 32'h0000_0044;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 4 || i == 9) check("starve_if_grant", {31'd0, bus.if_rsp_valid}, 32'd1);
    end
    idle_inputs();
    step();

    // Flush in the response cycle; a new IF request that cycle still completes.
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0010;
    step();
    bus.if_flush     = 1'b1;
    bus.if_req_addr  = 32'h0000_0020;
    step();
    idle_inputs();
    step();

    // Asynchronous reset while an LS read response is pending.
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 32'h0000_0020;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0010;
    step();
    rst_n = 1'b0;
    #1;
    check("arst_ls_rsp_valid", {31'd0, bus.ls_rsp_valid}, 32'd0);
    check("arst_ls_ready", {31'd0, bus.ls_req_ready}, 32'd0);
    check("arst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("arst_ls_rsp_data", bus.ls_rsp_data, 32'd0);
    idle_inputs();
    #4;
    rst_n = 1'b1;
    exp_q.delete();
    cnt_m   = 0;
    last_if = 32'd0;
    last_ls = 32'd0;
    @(posedge clk);
    #1;

    // Counter must restart from zero after reset.
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0050;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 32'h0000_0054;
    for (int i = 0; i < 6; i++) step();
    idle_inputs();
    step();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      bus.if_req_valid = ($urandom_range(0, 3) != 0);
      bus.if_req_addr  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2);
      bus.if_flush     = ($urandom_range(0, 3) == 0);
      bus.ls_req_valid = ($urandom_range(0, 1) != 0);
      bus.ls_req_we    = ($urandom_range(0, 1) != 0);
      bus.ls_req_addr  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2);
      bus.ls_req_wdata = $urandom;
      step();
    end
    idle_inputs();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
